// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and constants for the ripple-carry adder operand issue block
package rca_pkg;

    localparam int ADD_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] a;
        logic [ADD_WIDTH-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/rca_op_fifo.sv
// rtl/rca_op_fifo.sv - synchronous operand-pair FIFO with a registered occupancy count
module rca_op_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Full/empty come only from the count register, so the pointers may wrap freely.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rca_operand_issue.sv
// rtl/rca_operand_issue.sv - operand FIFO, adder drive/capture FSM and carry-out event counter
module rca_operand_issue
    import rca_pkg::*;
#(
    parameter int WIDTH      = ADD_WIDTH,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH:0]   i_add_result,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_sum,
    output logic [CNT_W-1:0] o_carry_cnt
);

    state_e   state_q;
    state_e   state_d;
    op_pair_t in_pair;
    op_pair_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop;
    logic     accept;

    assign in_pair.a = i_op_a;
    assign in_pair.b = i_op_b;
    assign o_ready   = !fifo_full;
    assign accept    = o_valid && i_ready;

    rca_op_fifo #(
        .DATA_W($bits(op_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .push (i_valid),
        .pop  (pop),
        .wdata(in_pair),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = DONE;
            DONE: begin
                if (i_ready) begin
                    pop     = !fifo_empty;
                    state_d = fifo_empty ? IDLE : EXEC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers only change on a pop, so they hold steady through EXEC and DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_add_term1 <= '0;
            o_add_term2 <= '0;
            o_sum       <= '0;
            o_valid     <= 1'b0;
            o_carry_cnt <= '0;
        end else begin
            if (pop) begin
                o_add_term1 <= head.a;
                o_add_term2 <= head.b;
            end
            if (state_q == EXEC) begin
                o_sum   <= i_add_result;
                o_valid <= 1'b1;
            end else if (accept) begin
                o_valid <= 1'b0;
            end
            if (accept && o_sum[WIDTH] && (o_carry_cnt != '1)) begin
                o_carry_cnt <= o_carry_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rca_operand_issue.sv
// tb/tb_rca_operand_issue.sv - directed self-checking bench for rca_operand_issue with a behavioural adder
module tb_rca_operand_issue;

    localparam int WIDTH = 6;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_term1;
    logic [WIDTH-1:0] add_term2;
    logic [WIDTH:0]   add_result;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_sum;
    logic [CNT_W-1:0] o_carry_cnt;

    int vectors  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign add_result = {1'b0, add_term1} + {1'b0, add_term2};

    rca_operand_issue #(
        .WIDTH     (WIDTH),
        .FIFO_DEPTH(2),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_add_term1 (add_term1),
        .o_add_term2 (add_term2),
        .i_add_result(add_result),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_carry_cnt (o_carry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one pair with i_ready=1 and follow it through the 3-cycle latency to acceptance.
    task automatic run_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input int exp_sum, input int exp_cnt);
        i_valid = 1'b1;
        op_a    = a;
        op_b    = b;
        step();
        i_valid = 1'b0;
        check("lat_after_push", 32'(o_valid), 0);
        step();
        check("lat_after_pop", 32'(o_valid), 0);
        step();
        check("lat_valid", 32'(o_valid), 1);
        check("single_sum", 32'(o_sum), 32'(exp_sum));
        check("term1_drive", 32'(add_term1), 32'(a));
        step();
        check("accepted_clear", 32'(o_valid), 0);
        check("carry_cnt", 32'(o_carry_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int got[$];
        int seen;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        op_a    = '0;
        op_b    = '0;
        step();
        step();
        check("rst_valid", 32'(o_valid), 0);
        check("rst_sum", 32'(o_sum), 0);
        check("rst_term1", 32'(add_term1), 0);
        check("rst_term2", 32'(add_term2), 0);
        check("rst_cnt", 32'(o_carry_cnt), 0);
        rst_n = 1'b1;
        step();
        check("idle_ready", 32'(o_ready), 1);

        // Single op, then an overflowing op.
        run_single(6'd5, 6'd9, 14, 0);
        run_single(6'd63, 6'd1, 64, 1);

        // Backpressure: three pushes fill the FIFO while one result waits.
        i_ready = 1'b0;
        i_valid = 1'b1;
        op_a = 6'd1; op_b = 6'd1;
        step();
        op_a = 6'd2; op_b = 6'd2;
        step();
        op_a = 6'd3; op_b = 6'd3;
        step();
        check("bp_ready_low", 32'(o_ready), 0);
        check("bp_valid", 32'(o_valid), 1);
        check("bp_sum", 32'(o_sum), 2);

        // Full FIFO with a result pending: 10+10 must be refused.
        op_a = 6'd10; op_b = 6'd10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_ready_low", 32'(o_ready), 0);
            check("bp_hold_valid", 32'(o_valid), 1);
            check("bp_hold_sum", 32'(o_sum), 2);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) got.push_back(int'(o_sum));
            step();
        end
        check("drain_count", 32'(got.size()), 3);
        if (got.size() == 3) begin
            check("drain_0", 32'(got[0]), 2);
            check("drain_1", 32'(got[1]), 4);
            check("drain_2", 32'(got[2]), 6);
        end
        check("cnt_no_carry", 32'(o_carry_cnt), 1);

        // Reset mid-EXEC with the FIFO loaded.
        i_ready = 1'b0;
        i_valid = 1'b1;
        op_a = 6'd7; op_b = 6'd7;
        step();
        op_a = 6'd8; op_b = 6'd8;
        step();
        op_a = 6'd9; op_b = 6'd9;
        step();
        i_valid = 1'b0;
        check("rst_setup_sum", 32'(o_sum), 14);
        i_ready = 1'b1;
        step();
        check("rst_setup_term", 32'(add_term1), 8);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_sum", 32'(o_sum), 0);
        check("midrst_term1", 32'(add_term1), 0);
        check("midrst_term2", 32'(add_term2), 0);
        check("midrst_cnt", 32'(o_carry_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_valid) seen++;
        end
        check("no_stale_result", 32'(seen), 0);

        // Counter saturation with CNT_W=2.
        for (int k = 1; k <= 5; k++) begin
            run_single(6'd63, 6'd63, 126, (k < 3) ? k : 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
